mem_arbiter: RTL and testbench

//  Shares the single-port unified instruction/data memory between the multi-cycle

---
 rtl/mem_arb_pkg.sv | 18 +
 rtl/mem_arb_pick.sv | 24 ++
 rtl/mem_arbiter.sv | 117 +++++++++++
 tb/tb_mem_arbiter.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types for the CPU/DMA memory arbiter: FSM state encoding,
// requester identifiers and the wait-state counter width.
package mem_arb_pkg;

   localparam int WAIT_W = 4;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } state_t;

   typedef enum logic {
      REQ_CPU = 1'b0,
      REQ_DMA = 1'b1
   } req_id_t;

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational round-robin picker: a sole requester wins outright,
// on a tie the requester that was not granted last time wins.
module mem_arb_pick
   import mem_arb_pkg::*;
(
   input  logic    cpu_req,
   input  logic    dma_req,
   input  req_id_t last_gnt,
   output logic    valid,
   output req_id_t gnt_id
);

   always_comb begin
      // NOTE: every output gets a default first, so no path can infer a latch.
      valid  = cpu_req | dma_req;
      gnt_id = REQ_CPU;
      if (cpu_req && dma_req) begin
         gnt_id = (last_gnt == REQ_CPU) ? REQ_DMA : REQ_CPU;
      end else if (dma_req) begin
         gnt_id = REQ_DMA;
      end
   end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-port memory between the core and a DMA/debug loader with
// round-robin arbitration, programmable wait states and misalignment trapping.
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int AW   = 32,
   parameter int DW   = 32,
   parameter int WAIT = 1
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          cpu_req,
   input  logic          cpu_we,
   input  logic [AW-1:0] cpu_adr,
   input  logic [DW-1:0] cpu_wd,
   output logic [DW-1:0] cpu_rd,
   output logic          cpu_ack,
   output logic          cpu_err,
   input  logic          dma_req,
   input  logic          dma_we,
   input  logic [AW-1:0] dma_adr,
   input  logic [DW-1:0] dma_wd,
   output logic [DW-1:0] dma_rd,
   output logic          dma_ack,
   output logic          dma_err,
   output logic          mem_en,
   output logic          mem_we,
   output logic [AW-1:0] mem_adr,
   output logic [DW-1:0] mem_wd,
   input  logic [DW-1:0] mem_rd
);

   if (WAIT < 0 || WAIT > (2**WAIT_W - 1)) begin : g_wait_check
      $error("mem_arbiter: WAIT must be in 0..15");
   end

   state_t            state, state_nxt;
   req_id_t           last_gnt, win_id, pick_id;
   logic              win_we, err_q, pick_valid, last_cnt, resp;
   logic [WAIT_W-1:0] cnt;
   logic              pick_we;
   logic [AW-1:0]     pick_adr;
   logic [DW-1:0]     pick_wd;

   mem_arb_pick u_pick (
      .cpu_req  (cpu_req),
      .dma_req  (dma_req),
      .last_gnt (last_gnt),
      .valid    (pick_valid),
      .gnt_id   (pick_id)
   );

   assign pick_we  = (pick_id == REQ_CPU) ? cpu_we  : dma_we;
   assign pick_adr = (pick_id == REQ_CPU) ? cpu_adr : dma_adr;
   assign pick_wd  = (pick_id == REQ_CPU) ? cpu_wd  : dma_wd;
   assign last_cnt = (cnt == '0);

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (pick_valid) state_nxt = (pick_adr[1:0] != 2'b00) ? RESP : ACCESS;
         ACCESS:  if (last_cnt) state_nxt = RESP;
         RESP:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments only, so every register sees pre-edge values.
      if (reset) begin
         state    <= IDLE;
         last_gnt <= REQ_DMA;
         win_id   <= REQ_CPU;
         win_we   <= 1'b0;
         err_q    <= 1'b0;
         cnt      <= '0;
         mem_adr  <= '0;
         mem_wd   <= '0;
         cpu_rd   <= '0;
         dma_rd   <= '0;
      end else begin
         state <= state_nxt;
         case (state)
            IDLE: begin
               if (pick_valid) begin
                  win_id   <= pick_id;
                  win_we   <= pick_we;
                  mem_adr  <= pick_adr;
                  mem_wd   <= pick_wd;
                  last_gnt <= pick_id;
                  err_q    <= (pick_adr[1:0] != 2'b00);
                  cnt      <= WAIT_W'(WAIT);
               end
            end
            ACCESS: begin
               if (!last_cnt) begin
                  cnt <= cnt - 1'b1;
               end else if (!win_we) begin
                  if (win_id == REQ_CPU) cpu_rd <= mem_rd;
                  else                   dma_rd <= mem_rd;
               end
            end
            default: ;
         endcase
      end
   end

   // Strobes and acks are gated by reset so an aborted transfer never completes.
   assign mem_en  = (state == ACCESS) & ~reset;
   assign mem_we  = (state == ACCESS) & last_cnt & win_we & ~reset;
   assign resp    = (state == RESP) & ~reset;
   assign cpu_ack = resp & (win_id == REQ_CPU);
   assign dma_ack = resp & (win_id == REQ_DMA);
   assign cpu_err = cpu_ack & err_q;
   assign dma_err = dma_ack & err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: three instances (WAIT=1, 3, 0) each with a
// small behavioural memory; expected values are hand-computed constants.
module tb_mem_arbiter;

   logic        clk = 1'b0;
   logic [2:0]  reset, cpu_req, cpu_we, cpu_ack, cpu_err;
   logic [2:0]  dma_req, dma_we, dma_ack, dma_err, mem_en, mem_we;
   logic [31:0] cpu_adr [3], cpu_wd [3], cpu_rd [3];
   logic [31:0] dma_adr [3], dma_wd [3], dma_rd [3];
   logic [31:0] mem_adr [3], mem_wd [3], mem_rd [3];
   logic [31:0] mem [3][64];

   int checks = 0;
   int errors = 0;
   int en_cnt [3]   = '{default: 0};
   int we_cnt [3]   = '{default: 0};
   int cack_cnt [3] = '{default: 0};
   int dual_cnt [3] = '{default: 0};
   int ack_log [$];

   always #5 clk = ~clk;

   for (genvar i = 0; i < 3; i++) begin : g_dut
      mem_arbiter #(.AW(32), .DW(32), .WAIT(i == 0 ? 1 : (i == 1 ? 3 : 0))) u_dut (
         .clk     (clk),
         .reset   (reset[i]),
         .cpu_req (cpu_req[i]),
         .cpu_we  (cpu_we[i]),
         .cpu_adr (cpu_adr[i]),
         .cpu_wd  (cpu_wd[i]),
         .cpu_rd  (cpu_rd[i]),
         .cpu_ack (cpu_ack[i]),
         .cpu_err (cpu_err[i]),
         .dma_req (dma_req[i]),
         .dma_we  (dma_we[i]),
         .dma_adr (dma_adr[i]),
         .dma_wd  (dma_wd[i]),
         .dma_rd  (dma_rd[i]),
         .dma_ack (dma_ack[i]),
         .dma_err (dma_err[i]),
         .mem_en  (mem_en[i]),
         .mem_we  (mem_we[i]),
         .mem_adr (mem_adr[i]),
         .mem_wd  (mem_wd[i]),
         .mem_rd  (mem_rd[i])
      );
      assign mem_rd[i] = mem[i][mem_adr[i][7:2]];
   end

   always @(posedge clk) begin
      for (int i = 0; i < 3; i++) begin
         if (mem_we[i]) mem[i][mem_adr[i][7:2]] <= mem_wd[i];
      end
   end

   always @(negedge clk) begin
      for (int i = 0; i < 3; i++) begin
         if (mem_en[i])                en_cnt[i]++;
         if (mem_we[i])                we_cnt[i]++;
         if (cpu_ack[i])               cack_cnt[i]++;
         if (cpu_ack[i] && dma_ack[i]) dual_cnt[i]++;
      end
      if (cpu_ack[0]) ack_log.push_back(0);
      if (dma_ack[0]) ack_log.push_back(1);
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(negedge clk);
      #1;
   endtask

   task automatic wait_ack(input int k, input bit dma, input int max, output int cyc);
      bit seen = 1'b0;
      cyc = -1;
      for (int c = 1; c <= max && !seen; c++) begin
         step();
         if ((dma ? dma_ack[k] : cpu_ack[k]) === 1'b1) begin
            cyc  = c;
            seen = 1'b1;
         end
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int cyc, cyc_c, cyc_d, base_en, base_we, base_ack, base_dual;

      for (int i = 0; i < 3; i++) begin
         for (int j = 0; j < 64; j++) mem[i][j] = 32'h0;
         cpu_adr[i] = '0; cpu_wd[i] = '0; dma_adr[i] = '0; dma_wd[i] = '0;
      end
      mem[0][0]  = 32'hC0C0_0000;
      mem[0][1]  = 32'hD0D0_0001;
      mem[0][4]  = 32'hDEAD_BEEF;
      mem[0][12] = 32'h1234_5678;
      mem[1][20] = 32'hAAAA_5555;
      mem[2][16] = 32'h0BAD_CAFE;
      cpu_req = '0; cpu_we = '0; dma_req = '0; dma_we = '0;
      reset   = 3'b111;

      // Reset state
      repeat (3) step();
      check("rst_cpu_ack", cpu_ack[0], 1'b0);
      check("rst_dma_ack", dma_ack[0], 1'b0);
      check("rst_mem_en",  mem_en[0],  1'b0);
      check("rst_mem_we",  mem_we[0],  1'b0);
      check("rst_cpu_rd",  cpu_rd[0],  32'h0);
      check("rst_dma_rd",  dma_rd[0],  32'h0);
      check("rst_mem_adr", mem_adr[0], 32'h0);
      check("rst_mem_wd",  mem_wd[0],  32'h0);
      reset = 3'b000;
      step();
      check("idle_mem_en", mem_en[0], 1'b0);

      // 1: WAIT=1 CPU read
      base_en = en_cnt[0];
      cpu_we[0] = 1'b0; cpu_adr[0] = 32'h10; cpu_req[0] = 1'b1;
      wait_ack(0, 1'b0, 10, cyc);
      cpu_req[0] = 1'b0;
      check("t1_latency", cyc, 3);
      check("t1_cpu_rd",  cpu_rd[0], 32'hDEAD_BEEF);
      check("t1_cpu_err", cpu_err[0], 1'b0);
      check("t1_dma_ack", dma_ack[0], 1'b0);
      check("t1_en_cycles", en_cnt[0] - base_en, 2);
      step();
      check("t1_ack_pulse", cpu_ack[0], 1'b0);
      check("t1_rd_hold",   cpu_rd[0], 32'hDEAD_BEEF);

      // 2: both request from reset, CPU first then DMA
      reset[0] = 1'b1;
      step(); step();
      reset[0] = 1'b0;
      ack_log.delete();
      base_we = we_cnt[0];
      cyc_c = -1; cyc_d = -1;
      cpu_we[0] = 1'b1; cpu_adr[0] = 32'h20; cpu_wd[0] = 32'h11; cpu_req[0] = 1'b1;
      dma_we[0] = 1'b1; dma_adr[0] = 32'h24; dma_wd[0] = 32'h22; dma_req[0] = 1'b1;
      for (int c = 1; c <= 20; c++) begin
         step();
         if (cpu_ack[0]) begin cyc_c = c; cpu_req[0] = 1'b0; end
         if (dma_ack[0]) begin cyc_d = c; dma_req[0] = 1'b0; end
      end
      check("t2_cpu_ack_cyc", cyc_c, 3);
      check("t2_dma_ack_cyc", cyc_d, 7);
      check("t2_we_pulses", we_cnt[0] - base_we, 2);
      check("t2_mem20", mem[0][8], 32'h11);
      check("t2_mem24", mem[0][9], 32'h22);
      check("t2_ack_count", ack_log.size(), 2);
      check("t2_first_cpu", ack_log[0], 0);
      check("t2_second_dma", ack_log[1], 1);

      // 3: both held for six transactions -> strict alternation
      ack_log.delete();
      base_dual = dual_cnt[0];
      cpu_we[0] = 1'b0; cpu_adr[0] = 32'h00;
      dma_we[0] = 1'b0; dma_adr[0] = 32'h04;
      cpu_req[0] = 1'b1; dma_req[0] = 1'b1;
      for (int c = 0; c < 60 && ack_log.size() < 6; c++) step();
      cpu_req[0] = 1'b0; dma_req[0] = 1'b0;
      step(); step();
      check("t3_ack_count", ack_log.size(), 6);
      for (int i = 0; i < 6; i++) check($sformatf("t3_grant%0d", i), ack_log[i], i % 2);
      check("t3_dual_acks", dual_cnt[0] - base_dual, 0);
      check("t3_cpu_rd", cpu_rd[0], 32'hC0C0_0000);
      check("t3_dma_rd", dma_rd[0], 32'hD0D0_0001);

      // 4: misaligned DMA write
      base_en = en_cnt[0];
      dma_we[0] = 1'b1; dma_adr[0] = 32'h33; dma_wd[0] = 32'h55; dma_req[0] = 1'b1;
      wait_ack(0, 1'b1, 10, cyc);
      dma_req[0] = 1'b0;
      check("t4_latency", cyc, 1);
      check("t4_dma_err", dma_err[0], 1'b1);
      check("t4_cpu_ack", cpu_ack[0], 1'b0);
      step();
      check("t4_err_pulse", dma_err[0], 1'b0);
      check("t4_no_en", en_cnt[0] - base_en, 0);
      check("t4_mem_kept", mem[0][12], 32'h1234_5678);
      check("t4_dma_rd_kept", dma_rd[0], 32'hD0D0_0001);

      // 5: WAIT=3, reset during the second ACCESS cycle of a CPU write
      cpu_we[1] = 1'b1; cpu_adr[1] = 32'h50; cpu_wd[1] = 32'hCAFE_F00D; cpu_req[1] = 1'b1;
      step();
      check("t5_access1_en", mem_en[1], 1'b1);
      base_we  = we_cnt[1];
      base_ack = cack_cnt[1];
      step();
      reset[1] = 1'b1; cpu_req[1] = 1'b0;
      #1;
      check("t5_en_gated", mem_en[1], 1'b0);
      check("t5_we_gated", mem_we[1], 1'b0);
      step();
      reset[1] = 1'b0;
      check("t5_post_en",  mem_en[1],  1'b0);
      check("t5_post_ack", cpu_ack[1], 1'b0);
      check("t5_post_adr", mem_adr[1], 32'h0);
      check("t5_post_wd",  mem_wd[1],  32'h0);
      repeat (8) step();
      check("t5_no_ack", cack_cnt[1] - base_ack, 0);
      check("t5_no_we",  we_cnt[1] - base_we, 0);
      check("t5_mem_kept", mem[1][20], 32'hAAAA_5555);
      cpu_we[1] = 1'b0; cpu_req[1] = 1'b1;
      wait_ack(1, 1'b0, 12, cyc);
      cpu_req[1] = 1'b0;
      check("t5_read_latency", cyc, 5);
      check("t5_read_data", cpu_rd[1], 32'hAAAA_5555);
      check("t5_read_err",  cpu_err[1], 1'b0);

      // 6: WAIT=0 DMA read, request dropped the cycle after grant
      base_en = en_cnt[2];
      dma_we[2] = 1'b0; dma_adr[2] = 32'h40; dma_req[2] = 1'b1;
      step();
      dma_req[2] = 1'b0;
      check("t6_no_early_ack", dma_ack[2], 1'b0);
      step();
      check("t6_ack", dma_ack[2], 1'b1);
      check("t6_dma_rd", dma_rd[2], 32'h0BAD_CAFE);
      check("t6_dma_err", dma_err[2], 1'b0);
      step();
      check("t6_en_cycles", en_cnt[2] - base_en, 1);
      check("t6_ack_pulse", dma_ack[2], 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
